// File: rtl/secuenciador_alu_pkg.sv
// Shared definitions for the multicycle ALU sequencer: opcodes, FSM states
// and the routing helper that decides which operations use the iterative engine.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_SUMA  = 4'b0100;
    localparam logic [3:0] OP_RESTA = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_NEQ   = 4'b1001;

    typedef enum logic [1:0] {
        REPOSO = 2'b00,
        UNICO  = 2'b01,
        MULT   = 2'b10,
        DIVI   = 2'b11
    } estado_t;

    // Divide by zero is resolved in a single cycle, so it never iterates.
    function automatic logic es_iterativa(input logic [3:0] op, input logic divisor_cero);
        logic r;
        r = (op == OP_MUL) || ((op == OP_DIV) && !divisor_cero);
        return r;
    endfunction

endpackage

// File: rtl/secuenciador_alu_if.sv
// Handshake and data bus between the pipeline control and the ALU sequencer.
interface secuenciador_alu_if #(
    parameter int WIDTH = 32
);
    logic             inicio;
    logic [3:0]       sal_alu;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] resultado_hi;
    logic             cero;
    logic             listo;
    logic             ocupado;
    logic             error;

    modport master (
        output inicio, sal_alu, op_a, op_b,
        input  resultado, resultado_hi, cero, listo, ocupado, error
    );

    modport slave (
        input  inicio, sal_alu, op_a, op_b,
        output resultado, resultado_hi, cero, listo, ocupado, error
    );
endinterface

// File: rtl/secuenciador_alu_muldiv.sv
// Iterative engine: shift/add unsigned multiply and restoring unsigned divide,
// one bit per step, with its own iteration counter.
module muldiv_iterativo #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic             modo,       // 0 multiply, 1 divide
    input  logic             paso,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fin_cuenta
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] b_r;
    logic             modo_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   suma_s;
    logic [WIDTH:0]   prueba_s;
    logic [WIDTH-1:0] sig_hi_s;
    logic [WIDTH-1:0] sig_lo_s;

    // Next value of the {hi, lo} pair for one multiply or divide iteration
    always_comb begin
        sig_hi_s = hi_r;
        sig_lo_s = lo_r;
        suma_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        // Remainder shifted left can reach WIDTH+1 bits, so the trial subtract is one bit wider.
        prueba_s = {hi_r, lo_r[WIDTH-1]} - {1'b0, b_r};
        if (!modo_r) begin
            sig_hi_s = suma_s[WIDTH:1];
            sig_lo_s = {suma_s[0], lo_r[WIDTH-1:1]};
        end else if (!prueba_s[WIDTH]) begin
            sig_hi_s = prueba_s[WIDTH-1:0];
            sig_lo_s = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            sig_hi_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
            sig_lo_s = {lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Operand load, per-step update and iteration counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            modo_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (carga) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= a;
            b_r    <= b;
            modo_r <= modo;
            cnt_r  <= CW'(WIDTH);
        end else if (paso && !fin_cuenta) begin
            hi_r   <= sig_hi_s;
            lo_r   <= sig_lo_s;
            cnt_r  <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign hi         = hi_r;
    assign lo         = lo_r;
    assign fin_cuenta = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/secuenciador_alu.sv
// Multicycle ALU sequencer: accepts one operation at a time, resolves simple ops
// in one cycle and hands multiply/divide to the iterative engine.
module secuenciador_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic              clk,
    input  logic              reset,
    secuenciador_alu_if.slave bus
);

    estado_t          estado_r;
    estado_t          estado_s;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic             acepta_s;
    logic             carga_s;
    logic             modo_s;
    logic             paso_s;
    logic             fin_s;

    logic [WIDTH-1:0] uni_res_s;
    logic [WIDTH-1:0] uni_hi_s;
    logic             uni_err_s;
    logic [WIDTH-1:0] nxt_res_s;
    logic [WIDTH-1:0] nxt_hi_s;
    logic             nxt_err_s;

    logic [WIDTH-1:0] eng_hi_s;
    logic [WIDTH-1:0] eng_lo_s;
    logic             eng_fin_s;

    logic [WIDTH-1:0] resultado_r;
    logic [WIDTH-1:0] resultado_hi_r;
    logic             cero_r;
    logic             listo_r;
    logic             ocupado_r;
    logic             error_r;

    assign acepta_s = (estado_r == REPOSO) && bus.inicio;

    muldiv_iterativo #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .carga      (carga_s),
        .modo       (modo_s),
        .paso       (paso_s),
        .a          (bus.op_a),
        .b          (bus.op_b),
        .hi         (eng_hi_s),
        .lo         (eng_lo_s),
        .fin_cuenta (eng_fin_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r <= REPOSO;
        end else begin
            estado_r <= estado_s;
        end
    end

    // Operand and opcode capture at acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r <= 4'b0000;
            a_r  <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
        end else if (acepta_s) begin
            op_r <= bus.sal_alu;
            a_r  <= bus.op_a;
            b_r  <= bus.op_b;
        end
    end

    // Single-cycle results; a divide only reaches here when the divisor was zero
    always_comb begin
        uni_res_s = {WIDTH{1'b0}};
        uni_hi_s  = {WIDTH{1'b0}};
        uni_err_s = 1'b0;
        case (op_r)
            OP_AND:   uni_res_s = a_r & b_r;
            OP_OR:    uni_res_s = a_r | b_r;
            OP_SUMA:  uni_res_s = a_r + b_r;
            OP_RESTA: uni_res_s = a_r - b_r;
            OP_SLT:   uni_res_s = ($signed(a_r) < $signed(b_r)) ?
                                  {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            OP_NEQ:   uni_res_s = (a_r != b_r) ?
                                  {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            OP_DIV: begin
                uni_res_s = {WIDTH{1'b1}};
                uni_hi_s  = a_r;
                uni_err_s = 1'b1;
            end
            default:  uni_err_s = 1'b1;
        endcase
    end

    // Next state, engine control and the values to publish on completion
    always_comb begin
        estado_s  = estado_r;
        carga_s   = 1'b0;
        modo_s    = 1'b0;
        paso_s    = 1'b0;
        fin_s     = 1'b0;
        nxt_res_s = {WIDTH{1'b0}};
        nxt_hi_s  = {WIDTH{1'b0}};
        nxt_err_s = 1'b0;
        case (estado_r)
            REPOSO: begin
                if (!bus.inicio) begin
                    estado_s = REPOSO;
                end else if (es_iterativa(bus.sal_alu, (bus.op_b == {WIDTH{1'b0}}))) begin
                    carga_s  = 1'b1;
                    modo_s   = (bus.sal_alu == OP_DIV);
                    estado_s = (bus.sal_alu == OP_DIV) ? DIVI : MULT;
                end else begin
                    estado_s = UNICO;
                end
            end
            UNICO: begin
                fin_s     = 1'b1;
                nxt_res_s = uni_res_s;
                nxt_hi_s  = uni_hi_s;
                nxt_err_s = uni_err_s;
                estado_s  = REPOSO;
            end
            MULT, DIVI: begin
                if (eng_fin_s) begin
                    fin_s     = 1'b1;
                    nxt_res_s = eng_lo_s;
                    nxt_hi_s  = eng_hi_s;
                    estado_s  = REPOSO;
                end else begin
                    paso_s = 1'b1;
                end
            end
            default: estado_s = REPOSO;
        endcase
    end

    // Registered outputs; results hold until the next completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resultado_r    <= {WIDTH{1'b0}};
            resultado_hi_r <= {WIDTH{1'b0}};
            cero_r         <= 1'b0;
            listo_r        <= 1'b0;
            ocupado_r      <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            listo_r   <= fin_s;
            ocupado_r <= (estado_s != REPOSO);
            if (fin_s) begin
                resultado_r    <= nxt_res_s;
                resultado_hi_r <= nxt_hi_s;
                cero_r         <= (nxt_res_s == {WIDTH{1'b0}});
                error_r        <= nxt_err_s;
            end
        end
    end

    assign bus.resultado    = resultado_r;
    assign bus.resultado_hi = resultado_hi_r;
    assign bus.cero         = cero_r;
    assign bus.listo        = listo_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.error        = error_r;

endmodule

// File: tb/tb_secuenciador_alu.sv
// Self-checking bench for secuenciador_alu: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_secuenciador_alu;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    secuenciador_alu_if #(.WIDTH(W)) bus ();

    secuenciador_alu #(.WIDTH(W), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         err;
        logic         cer;
        logic [7:0]   lat;
    } vec_t;

    vec_t tabla [16];

    task automatic chk(input string nombre, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nombre, got, exp);
        end
    endtask

    // Reference: computed straight from the operation definitions
    function automatic vec_t modelo(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t m;
        logic [2*W-1:0] p;
        m = '0;
        m.op = op; m.a = a; m.b = b; m.lat = 8'd1;
        case (op)
            4'b0000: m.res = a & b;
            4'b0001: m.res = a | b;
            4'b0100: m.res = a + b;
            4'b0101: m.res = a - b;
            4'b1000: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: m.res = (a != b) ? 32'd1 : 32'd0;
            4'b0110: begin
                p = {32'd0, a} * {32'd0, b};
                m.res = p[W-1:0]; m.hi = p[2*W-1:W]; m.lat = 8'(W + 1);
            end
            4'b0111: begin
                if (b == 32'd0) begin
                    m.res = 32'hFFFF_FFFF; m.hi = a; m.err = 1'b1;
                end else begin
                    m.res = a / b; m.hi = a % b; m.lat = 8'(W + 1);
                end
            end
            default: m.err = 1'b1;
        endcase
        m.cer = (m.res == 32'd0);
        return m;
    endfunction

    // Issue one operation and wait (bounded) for listo
    task automatic ejecutar(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int lat, output int ocup_mal);
        bus.inicio = 1'b1; bus.sal_alu = op; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        lat = 0; ocup_mal = 0;
        if (bus.ocupado !== 1'b1) ocup_mal++;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.listo === 1'b1) break;
            if (bus.ocupado !== 1'b1) ocup_mal++;
        end
    endtask

    task automatic comparar(input string nombre, input vec_t e, input int lat, input int ocup_mal);
        chk({nombre, ".res"}, 64'(bus.resultado), 64'(e.res));
        chk({nombre, ".hi"}, 64'(bus.resultado_hi), 64'(e.hi));
        chk({nombre, ".err"}, 64'(bus.error), 64'(e.err));
        chk({nombre, ".cero"}, 64'(bus.cero), 64'(e.cer));
        chk({nombre, ".lat"}, 64'(lat), 64'(e.lat));
        chk({nombre, ".ocupado_antes"}, 64'(ocup_mal), 64'd0);
        chk({nombre, ".ocupado_listo"}, 64'(bus.ocupado), 64'd0);
    endtask

    initial begin
        int   lat;
        int   om;
        int   pulsos;
        vec_t e;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0] ops_validas [8];

        checks = 0; failures = 0;
        clk = 1'b0; reset = 1'b0;
        bus.inicio = 1'b0; bus.sal_alu = 4'h0; bus.op_a = 32'd0; bus.op_b = 32'd0;
        ops_validas = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};

        tabla[0]  = '{4'b0100, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1'b0, 8'd1};
        tabla[1]  = '{4'b0101, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 8'd1};
        tabla[2]  = '{4'b0110, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0, 1'b1, 8'd33};
        tabla[3]  = '{4'b0111, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 8'd33};
        tabla[4]  = '{4'b0111, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 8'd1};
        tabla[5]  = '{4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 8'd1};
        tabla[6]  = '{4'b1001, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1, 8'd1};
        tabla[7]  = '{4'b1111, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 1'b1, 8'd1};
        tabla[8]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'd0, 1'b0, 1'b0, 8'd1};
        tabla[9]  = '{4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'd0, 1'b0, 1'b0, 8'd1};
        tabla[10] = '{4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 8'd33};
        tabla[11] = '{4'b0111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 8'd33};
        tabla[12] = '{4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 8'd1};
        tabla[13] = '{4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 8'd1};
        tabla[14] = '{4'b0111, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b1, 8'd33};
        tabla[15] = '{4'b0010, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 1'b1, 8'd1};

        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({bus.resultado, bus.resultado_hi, bus.cero, bus.listo, bus.ocupado, bus.error}), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Directed table, issued back-to-back
        for (int i = 0; i < 16; i++) begin
            ejecutar(tabla[i].op, tabla[i].a, tabla[i].b, lat, om);
            comparar($sformatf("tabla%0d", i), tabla[i], lat, om);
        end

        // inicio during a multiply must be ignored
        @(posedge clk); #1;
        bus.inicio = 1'b1; bus.sal_alu = 4'b0110; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 5) begin
                bus.inicio = 1'b1; bus.sal_alu = 4'b0100; bus.op_a = 32'd100; bus.op_b = 32'd200;
            end else begin
                bus.inicio = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (bus.listo === 1'b1) break;
        end
        bus.inicio = 1'b0;
        chk("ignorado.res", 64'(bus.resultado), 64'd15);
        chk("ignorado.lat", 64'(lat), 64'd33);
        @(posedge clk); #1;
        chk("ignorado.sin_listo", 64'({bus.listo, bus.ocupado}), 64'd0);
        chk("retencion.res", 64'(bus.resultado), 64'd15);

        // Asynchronous reset in the middle of a divide
        bus.inicio = 1'b1; bus.sal_alu = 4'b0111; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_async", 64'({bus.resultado, bus.resultado_hi, bus.cero, bus.listo, bus.ocupado, bus.error}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.listo === 1'b1) pulsos++;
        end
        chk("reset_sin_listo", 64'(pulsos), 64'd0);
        e = modelo(4'b0100, 32'd1, 32'd1);
        ejecutar(4'b0100, 32'd1, 32'd1, lat, om);
        comparar("post_reset", e, lat, om);

        // Randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 8) op = ops_validas[$urandom_range(0, 7)];
            else op = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = a;
                default: b = $urandom;
            endcase
            e = modelo(op, a, b);
            ejecutar(op, a, b, lat, om);
            comparar($sformatf("rnd%0d_op%0h", n, op), e, lat, om);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
